// File: rtl/semi_cpu_pkg.sv
// Shared definitions for the semi CPU: datapath widths, decoded-instruction
// field widths and ALU opcodes, used by the decoder and the execute stage.
package semi_cpu_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NREGS     = 32;
    localparam int unsigned REG_IDX_W = $clog2(NREGS);
    localparam int unsigned IMM_W     = 16;
    localparam int unsigned ALU_OP_W  = 3;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = 3'b010;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 3'b011;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 3'b100;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 3'b101;
    localparam logic [ALU_OP_W-1:0] OP_ADDI = 3'b110;
    localparam logic [ALU_OP_W-1:0] OP_ANDI = 3'b111;

    // Opcodes 000 and 001 carry no operation.
    function automatic logic is_nop(input logic [ALU_OP_W-1:0] op);
        return op[2:1] == 2'b00;
    endfunction

endpackage

// File: rtl/regfile.sv
// Register file: two combinational read ports, one debug read port and one
// synchronous write port; r0 reads as zero and ignores writes.
module regfile
    import semi_cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [REG_IDX_W-1:0] i_waddr,
    input  logic [DATA_W-1:0]    i_wdata,
    input  logic [REG_IDX_W-1:0] i_raddr_a,
    output logic [DATA_W-1:0]    o_rdata_a,
    input  logic [REG_IDX_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0]    o_rdata_b,
    input  logic [REG_IDX_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0]    o_dbg_data
);

    logic [DATA_W-1:0] r_mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = (i_raddr_a  == '0) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b  = (i_raddr_b  == '0) ? '0 : r_mem[i_raddr_b];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/exec_stage.sv
// Execute/writeback stage: operand fetch with forwarding from the pending
// result, ALU, output register, and commit to the register file on handoff.
module exec_stage
    import semi_cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rs,
    input  logic [REG_IDX_W-1:0] in_rt,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [IMM_W-1:0]     in_imm,
    input  logic [ALU_OP_W-1:0]  in_alu_op,
    input  logic                 in_reg_write,
    input  logic                 in_alu_src,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic                 out_zero,
    input  logic [REG_IDX_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]    dbg_data
);

    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_out_data;
    logic [REG_IDX_W-1:0] r_out_rd;
    logic                 r_out_zero;

    logic                 w_accept;
    logic                 w_commit;
    logic                 w_load;
    logic                 w_fwd_a;
    logic                 w_fwd_b;
    logic [DATA_W-1:0]    w_rf_a;
    logic [DATA_W-1:0]    w_rf_b;
    logic [DATA_W-1:0]    w_op_a;
    logic [DATA_W-1:0]    w_op_b;
    logic [DATA_W-1:0]    w_imm_ext;
    logic [DATA_W-1:0]    w_result;
    logic [REG_IDX_W-1:0] w_dest;

    regfile u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_commit),
        .i_waddr    (r_out_rd),
        .i_wdata    (r_out_data),
        .i_raddr_a  (in_rs),
        .o_rdata_a  (w_rf_a),
        .i_raddr_b  (in_rt),
        .o_rdata_b  (w_rf_b),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_commit = r_out_valid && out_ready;
    assign w_load   = w_accept && in_reg_write && !is_nop(in_alu_op);

    // An accept only happens when the pending result is leaving, so forwarding
    // it gives the operand the value the register holds after this edge.
    assign w_fwd_a = r_out_valid && (r_out_rd != '0) && (r_out_rd == in_rs);
    assign w_fwd_b = r_out_valid && (r_out_rd != '0) && (r_out_rd == in_rt) && !in_alu_src;

    assign w_imm_ext = (in_alu_op == OP_ANDI) ? {{(DATA_W-IMM_W){1'b0}}, in_imm}
                                              : {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    assign w_op_a    = w_fwd_a ? r_out_data : w_rf_a;
    assign w_op_b    = in_alu_src ? w_imm_ext : (w_fwd_b ? r_out_data : w_rf_b);
    assign w_dest    = in_alu_src ? in_rt : in_rd;

    always_comb begin
        w_result = '0;
        case (in_alu_op)
            OP_ADD, OP_ADDI: w_result = w_op_a + w_op_b;
            OP_SUB:          w_result = w_op_a - w_op_b;
            OP_AND, OP_ANDI: w_result = w_op_a & w_op_b;
            OP_OR:           w_result = w_op_a | w_op_b;
            default:         w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_rd    <= '0;
            r_out_zero  <= 1'b1;
        end else if (w_accept) begin
            r_out_valid <= w_load;
            if (w_load) begin
                r_out_data <= w_result;
                r_out_rd   <= w_dest;
                r_out_zero <= (w_result == '0);
            end
        end else if (w_commit) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_rd    = r_out_rd;
    assign out_zero  = r_out_zero;

endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: directed scenarios plus random traffic, checked against
// an architectural model (register values with the in-flight result applied).
module tb_exec_stage;
    import semi_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [2:0]  in_alu_op;
    logic        in_reg_write, in_alu_src;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_zero;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int total = 0;
    int bad   = 0;

    // Model: committed registers plus the one result still in flight.
    logic [31:0] m_regs [32];
    logic        m_pv;
    logic [31:0] m_pd;
    logic [4:0]  m_prd;

    exec_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .in_rd        (in_rd),
        .in_imm       (in_imm),
        .in_alu_op    (in_alu_op),
        .in_reg_write (in_reg_write),
        .in_alu_src   (in_alu_src),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_rd       (out_rd),
        .out_zero     (out_zero),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value a program would see for register idx once the in-flight result lands.
    function automatic logic [31:0] view(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (m_pv && m_prd == idx) return m_pd;
        return m_regs[idx];
    endfunction

    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] rtv, input logic [15:0] imm,
                                              input logic src);
        logic [31:0] b;
        int signed   simm;
        simm = int'(signed'(imm));
        if (!src)              b = rtv;
        else if (op == 3'b111) b = 32'(imm);
        else                   b = 32'(simm);
        case (op)
            3'b010, 3'b110: return a + b;
            3'b011:         return a - b;
            3'b100, 3'b111: return a & b;
            3'b101:         return a | b;
            default:        return 32'd0;
        endcase
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_pv));
        if (m_pv) begin
            chk("out_data", out_data, m_pd);
            chk("out_rd", 32'(out_rd), 32'(m_prd));
            chk("out_zero", 32'(out_zero), 32'(m_pd == 0));
        end
    endtask

    task automatic dbg_chk(input logic [4:0] addr);
        dbg_addr = addr;
        #1;
        chk("dbg_data", dbg_data, (addr == 0) ? 32'd0 : m_regs[addr]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pv = 1'b0; m_pd = 32'd0; m_prd = 5'd0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd1);
    endtask

    task automatic issue(input logic v, input logic [2:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                         input logic rw, input logic src, input logic ordy);
        logic        exp_rdy, acc, com;
        logic [31:0] res;
        logic [4:0]  dst;
        in_valid = v; in_alu_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_reg_write = rw; in_alu_src = src; out_ready = ordy;
        #1;
        exp_rdy = !m_pv || ordy;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        com = m_pv && ordy;
        res = alu_model(op, view(rs), view(rt), imm, src);
        dst = src ? rt : rd;
        if (com && m_prd != 0) m_regs[m_prd] = m_pd;
        if (acc) begin
            if (rw && op != 3'b000 && op != 3'b001) begin
                m_pv = 1'b1; m_pd = res; m_prd = dst;
            end else begin
                m_pv = 1'b0;
            end
        end else if (com) begin
            m_pv = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input logic ordy);
        issue(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 16'd0, 1'b0, 1'b0, ordy);
    endtask

    initial begin
        in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0; in_alu_op = 0;
        in_reg_write = 0; in_alu_src = 0; dbg_addr = 0;

        do_reset();
        dbg_chk(5'd1);
        dbg_chk(5'd31);

        // ADDI r1 = r0 + 0xFFFF (sign-extended)
        issue(1, OP_ADDI, 5'd0, 5'd1, 5'd0, 16'hFFFF, 1, 1, 1);
        chk("addi_data", out_data, 32'hFFFF_FFFF);
        chk("addi_rd", 32'(out_rd), 32'd1);
        idle(1);
        dbg_chk(5'd1);
        chk("addi_commit", dbg_data, 32'hFFFF_FFFF);

        // Back-to-back hazard
        issue(1, OP_ADDI, 5'd0, 5'd2, 5'd0, 16'd5, 1, 1, 1);
        issue(1, OP_ADD, 5'd2, 5'd2, 5'd3, 16'd0, 1, 0, 1);
        chk("fwd_data", out_data, 32'd10);
        idle(1);
        dbg_chk(5'd3);
        chk("fwd_commit", dbg_data, 32'd10);

        // ANDI zero-extension
        issue(1, OP_ADDI, 5'd0, 5'd4, 5'd0, 16'hFFFF, 1, 1, 1);
        issue(1, OP_ANDI, 5'd4, 5'd5, 5'd0, 16'h8000, 1, 1, 1);
        chk("andi_data", out_data, 32'h0000_8000);
        chk("andi_zero", 32'(out_zero), 32'd0);

        // SUB wrap
        issue(1, OP_ADDI, 5'd0, 5'd6, 5'd0, 16'd0, 1, 1, 1);
        chk("zero_flag", 32'(out_zero), 32'd1);
        issue(1, OP_ADDI, 5'd0, 5'd7, 5'd0, 16'd1, 1, 1, 1);
        issue(1, OP_SUB, 5'd6, 5'd7, 5'd8, 16'd0, 1, 0, 1);
        chk("sub_wrap", out_data, 32'hFFFF_FFFF);
        idle(1);

        // Backpressure: 3 stalled cycles, then accepted as out_ready rises
        issue(1, OP_ADDI, 5'd0, 5'd10, 5'd0, 16'd7, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            issue(1, OP_ADD, 5'd10, 5'd10, 5'd11, 16'd0, 1, 0, 0);
            chk("stall_ready", 32'(in_ready), 32'd0);
            chk("stall_data", out_data, 32'd7);
        end
        issue(1, OP_ADD, 5'd10, 5'd10, 5'd11, 16'd0, 1, 0, 1);
        chk("stall_release", out_data, 32'd14);
        idle(1);

        // Destination r0, then use r0 right behind it
        issue(1, OP_ADDI, 5'd0, 5'd0, 5'd0, 16'h1234, 1, 1, 1);
        issue(1, OP_ADD, 5'd0, 5'd0, 5'd12, 16'd0, 1, 0, 1);
        chk("r0_fwd", out_data, 32'd0);
        idle(1);
        dbg_chk(5'd0);

        // NOP opcodes produce nothing
        issue(1, 3'b000, 5'd1, 5'd1, 5'd13, 16'd0, 1, 0, 1);
        chk("nop0_valid", 32'(out_valid), 32'd0);
        issue(1, 3'b001, 5'd1, 5'd1, 5'd13, 16'd0, 1, 0, 1);
        chk("nop1_valid", 32'(out_valid), 32'd0);
        issue(1, OP_ADD, 5'd1, 5'd1, 5'd13, 16'd0, 0, 0, 1);
        dbg_chk(5'd13);

        // Reset while a result is stalled
        issue(1, OP_ADDI, 5'd0, 5'd9, 5'd0, 16'd5, 1, 1, 0);
        idle(0);
        do_reset();
        dbg_chk(5'd9);
        chk("rst_discard", dbg_data, 32'd0);

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            logic [2:0] op;
            logic       src;
            op  = 3'($urandom_range(0, 7));
            src = (op == OP_ADDI || op == OP_ANDI);
            issue(1'($urandom_range(0, 4) != 0), op, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom_range(0, 7) != 0), src, 1'($urandom_range(0, 3) != 0));
            if (n % 8 == 0) dbg_chk(5'($urandom_range(0, 7)));
        end
        idle(1);
        for (int r = 0; r < 8; r++) dbg_chk(5'(r));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
